// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC sequencer, single-outstanding memory read, and decode FIFO with redirect/flush.
// Optional feature (macro IFU_STALL_COUNT_EN): saturating request-stall counter output.
module instruction_fetch_unit #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int PC_INC   = 4,
  parameter int RESET_PC = 0,
  parameter int DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              busy
`ifdef IFU_STALL_COUNT_EN
  ,
  output logic [15:0]       stall_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] INC_C      = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                   state_r;
  state_t                   next_state_s;
  logic [ADDR_W-1:0]        pc_r;
  logic [ADDR_W-1:0]        req_pc_r;
  logic                     req_valid_r;
  logic                     inst_valid_r;
  logic                     busy_r;
  logic [DATA_W+ADDR_W-1:0] fifo_r [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [CNT_W-1:0]         count_r;
  logic [CNT_W-1:0]         count_next_s;
  logic                     handshake_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     slot_free_s;

  // A redirect both flushes the FIFO and kills any write or pop in the same cycle.
  assign handshake_s = req_valid_r & mem_req_ready;
  assign push_s      = (state_r == S_WAIT) & mem_rsp_valid & ~redirect_valid;
  assign pop_s       = inst_valid_r & inst_ready & ~redirect_valid;
  assign slot_free_s = start & (count_next_s < DEPTH_C);

  // Occupancy after this cycle's push/pop/flush; drives the request credit check.
  always_comb begin
    count_next_s = count_r;
    if (redirect_valid) begin
      count_next_s = {CNT_W{1'b0}};
    end else begin
      count_next_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Next-state selection; redirect has priority over every normal transition.
  always_comb begin
    next_state_s = state_r;
    if (redirect_valid) begin
      case (state_r)
        S_IDLE:          next_state_s = start ? S_REQ : S_IDLE;
        S_REQ:           next_state_s = mem_req_ready ? S_DRAIN : S_REQ;
        S_WAIT, S_DRAIN: next_state_s = mem_rsp_valid ? (start ? S_REQ : S_IDLE) : S_DRAIN;
        default:         next_state_s = S_IDLE;
      endcase
    end else begin
      case (state_r)
        S_IDLE:          next_state_s = slot_free_s ? S_REQ : S_IDLE;
        S_REQ:           next_state_s = mem_req_ready ? S_WAIT : S_REQ;
        S_WAIT, S_DRAIN: next_state_s = mem_rsp_valid ? (slot_free_s ? S_REQ : S_IDLE) : state_r;
        default:         next_state_s = S_IDLE;
      endcase
    end
  end

  // FSM state, PC, and registered request/busy outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      pc_r        <= RESET_PC_C;
      req_pc_r    <= {ADDR_W{1'b0}};
      req_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      req_valid_r <= (next_state_s == S_REQ);
      busy_r      <= (next_state_s == S_WAIT) | (next_state_s == S_DRAIN) |
                     (count_next_s != {CNT_W{1'b0}});
      if (redirect_valid) begin
        pc_r <= redirect_addr;
      end else if (handshake_s) begin
        req_pc_r <= pc_r;
        pc_r     <= pc_r + INC_C;
      end
    end
  end

  // Instruction FIFO storage and pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      inst_valid_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_r[i] <= {(DATA_W+ADDR_W){1'b0}};
      end
    end else begin
      count_r      <= count_next_s;
      inst_valid_r <= (count_next_s != {CNT_W{1'b0}});
      if (redirect_valid) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
        if (push_s) begin
          fifo_r[wr_ptr_r] <= {mem_rsp_data, req_pc_r};
          wr_ptr_r         <= wr_ptr_r + PTR_W'(1'b1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
        end
      end
    end
  end

  assign mem_req_valid          = req_valid_r;
  assign mem_req_addr           = pc_r;
  assign inst_valid             = inst_valid_r;
  assign {inst_data, inst_pc}   = fifo_r[rd_ptr_r];
  assign busy                   = busy_r;

`ifdef IFU_STALL_COUNT_EN
  logic [15:0] stall_r;

  // Saturating count of cycles where a request waits for the memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_r <= 16'h0000;
    end else if (redirect_valid) begin
      stall_r <= 16'h0000;
    end else if (req_valid_r && !mem_req_ready && (stall_r != 16'hFFFF)) begin
      stall_r <= stall_r + 16'd1;
    end
  end

  assign stall_count = stall_r;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: queue-based reference model of fetch/FIFO behaviour, directed scenarios, then random traffic.
module tb_instruction_fetch_unit;

  localparam int DEPTH  = 4;
  localparam int PC_INC = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [15:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [15:0] inst_pc;
  logic        busy;
`ifdef IFU_STALL_COUNT_EN
  logic [15:0] stall_count;
  logic [15:0] stall_m;
`endif

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .start(start),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .busy(busy)
`ifdef IFU_STALL_COUNT_EN
    , .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] addr; logic discard; logic [7:0] wait_c; } pend_t;
  typedef struct packed { logic [31:0] data; logic [15:0] pc; } inst_t;

  pend_t       pend_q[$];
  inst_t       fifo_q[$];
  logic [15:0] acc_log[$];
  inst_t       pop_log[$];
  logic [15:0] model_pc;
  logic        p_rv, p_iv;
  logic [15:0] p_addr;
  int          n_tests, n_fail;
  int          lat_min, lat_max, live_cnt;
  bit          rand_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model update for the clock edge that just passed.
  task automatic step();
    pend_t p;
    inst_t e;
    if (p_iv && inst_ready && !redirect_valid && fifo_q.size() != 0)
      pop_log.push_back(fifo_q.pop_front());
    if (mem_rsp_valid && pend_q.size() != 0) begin
      p = pend_q.pop_front();
      if (!p.discard && !redirect_valid) begin
        e.data = mem_rsp_data;
        e.pc   = p.addr;
        fifo_q.push_back(e);
      end
    end
    if (p_rv && mem_req_ready) begin
      acc_log.push_back(p_addr);
      p.addr    = p_addr;
      p.discard = redirect_valid;
      p.wait_c  = 8'($urandom_range(lat_min, lat_max));
      pend_q.push_back(p);
      model_pc  = model_pc + 16'(PC_INC);
    end
`ifdef IFU_STALL_COUNT_EN
    if (redirect_valid) stall_m = 16'h0000;
    else if (p_rv && !mem_req_ready && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
`endif
    if (redirect_valid) begin
      fifo_q.delete();
      foreach (pend_q[i]) pend_q[i].discard = 1'b1;
      model_pc = redirect_addr;
    end
  endtask

  task automatic tick();
    logic c_start, c_rdy, c_redir;
    @(negedge clk);
    c_start = start;
    c_rdy   = mem_req_ready;
    c_redir = redirect_valid;
    step();
    chk("inst_valid", 64'(inst_valid), 64'(fifo_q.size() != 0));
    if (fifo_q.size() != 0) begin
      chk("inst_data", 64'(inst_data), 64'(fifo_q[0].data));
      chk("inst_pc", 64'(inst_pc), 64'(fifo_q[0].pc));
    end
    chk("busy", 64'(busy), 64'((pend_q.size() != 0) || (fifo_q.size() != 0)));
    if (mem_req_valid) begin
      chk("req_addr", 64'(mem_req_addr), 64'(model_pc));
      chk("one_outstanding", 64'(pend_q.size()), 64'd0);
      chk("credit", 64'(fifo_q.size() < DEPTH), 64'd1);
      if (!p_rv) chk("req_needs_start", 64'(c_start), 64'd1);
    end
    if (p_rv && !c_rdy && !c_redir) begin
      chk("req_hold_valid", 64'(mem_req_valid), 64'd1);
      chk("req_hold_addr", 64'(mem_req_addr), 64'(p_addr));
    end
`ifdef IFU_STALL_COUNT_EN
    chk("stall_count", 64'(stall_count), 64'(stall_m));
`endif
    if (!mem_req_valid && pend_q.size() == 0 && fifo_q.size() < DEPTH && c_start) begin
      live_cnt++;
      chk("req_liveness", 64'(live_cnt > 2), 64'd0);
    end else begin
      live_cnt = 0;
    end
    p_rv   = mem_req_valid;
    p_addr = mem_req_addr;
    p_iv   = inst_valid;
    if (pend_q.size() != 0 && pend_q[0].wait_c <= 8'd1) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hA5A5_0000 ^ {16'h0000, pend_q[0].addr} ^ (rand_data ? $urandom : 32'h0);
    end else begin
      if (pend_q.size() != 0) pend_q[0].wait_c = pend_q[0].wait_c - 8'd1;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0000_0000;
    end
  endtask

  task automatic do_reset(input bit mid, input bit stray);
    if (mid) begin
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("arst_req_valid", 64'(mem_req_valid), 64'd0);
      chk("arst_inst_valid", 64'(inst_valid), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
    end else begin
      reset = 1'b0;
    end
    redirect_valid = 1'b0;
    mem_rsp_valid  = 1'b0;
    pend_q.delete(); fifo_q.delete(); acc_log.delete(); pop_log.delete();
    model_pc = 16'h0000;
    live_cnt = 0;
`ifdef IFU_STALL_COUNT_EN
    stall_m = 16'h0000;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_inst_data", 64'(inst_data), 64'd0);
    chk("rst_inst_pc", 64'(inst_pc), 64'd0);
    chk("rst_req_addr", 64'(mem_req_addr), 64'd0);
    reset  = 1'b1;
    p_rv   = 1'b0;
    p_iv   = 1'b0;
    p_addr = mem_req_addr;
    if (stray) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic wait_acc(input int n, input string name);
    for (int k = 0; k < 200 && acc_log.size() < n; k++) tick();
    if (acc_log.size() < n) chk(name, 64'(acc_log.size()), 64'(n));
  endtask

  initial begin
    int npop, nacc;
    logic [15:0] exp_pc [4];
    exp_pc = '{16'h0000, 16'h0004, 16'h0008, 16'h000C};
    n_tests = 0; n_fail = 0;
    reset = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_addr = 16'h0000;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0; inst_ready = 1'b0;
    lat_min = 1; lat_max = 1; rand_data = 1'b0;

    // linear fetch
    do_reset(1'b0, 1'b0);
    start = 1'b1; mem_req_ready = 1'b1; inst_ready = 1'b1;
    repeat (30) tick();
    chk("lin_count", 64'(pop_log.size() >= 4), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("lin_pc", 64'(pop_log[i].pc), 64'(exp_pc[i]));
      chk("lin_data", 64'(pop_log[i].data), 64'({16'hA5A5, exp_pc[i]}));
    end

    // backpressure until full, then a single pop
    do_reset(1'b0, 1'b0);
    start = 1'b1; mem_req_ready = 1'b1; inst_ready = 1'b0;
    repeat (30) tick();
    chk("bp_acc_count", 64'(acc_log.size()), 64'd4);
    chk("bp_last_addr", 64'(acc_log[3]), 64'h000C);
    chk("bp_req_idle", 64'(mem_req_valid), 64'd0);
    chk("bp_head_pc", 64'(inst_pc), 64'h0000);
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    repeat (10) tick();
    chk("bp_acc_count2", 64'(acc_log.size()), 64'd5);
    chk("bp_next_addr", 64'(acc_log[4]), 64'h0010);
    chk("bp_pops", 64'(pop_log.size()), 64'd1);

    // request held while memory is not ready
    do_reset(1'b0, 1'b0);
    start = 1'b1; mem_req_ready = 1'b1; inst_ready = 1'b1;
    wait_acc(2, "hold_timeout_acc");
    mem_req_ready = 1'b0;
    for (int k = 0; k < 20 && !mem_req_valid; k++) tick();
    chk("hold_reached", 64'(mem_req_valid), 64'd1);
    repeat (5) tick();
    chk("hold_valid", 64'(mem_req_valid), 64'd1);
    chk("hold_addr", 64'(mem_req_addr), 64'h0008);
`ifdef IFU_STALL_COUNT_EN
    chk("hold_stall5", 64'(stall_count), 64'd5);
`endif
    mem_req_ready = 1'b1;
    repeat (10) tick();

    // redirect while waiting for the response of addr 12
    do_reset(1'b0, 1'b0);
    lat_min = 4; lat_max = 4;
    start = 1'b1; mem_req_ready = 1'b1; inst_ready = 1'b1;
    wait_acc(4, "rdw_timeout_acc");
    chk("rdw_acc12", 64'(acc_log[3]), 64'h000C);
    redirect_valid = 1'b1; redirect_addr = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    chk("rdw_flush", 64'(inst_valid), 64'd0);
    npop = pop_log.size(); nacc = acc_log.size();
    lat_min = 1; lat_max = 1;
    repeat (20) tick();
    chk("rdw_next_req", 64'(acc_log[nacc]), 64'h0100);
    chk("rdw_first_pc", 64'(pop_log[npop].pc), 64'h0100);

    // wrap around the top of the address space
    redirect_valid = 1'b1; redirect_addr = 16'hFFFC;
    tick();
    redirect_valid = 1'b0;
    nacc = acc_log.size();
    repeat (20) tick();
    chk("wrap_fffc", 64'(acc_log[nacc]), 64'hFFFC);
    chk("wrap_0000", 64'(acc_log[nacc + 1]), 64'h0000);

    // asynchronous reset in the middle of a wait, stray response afterwards
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 20 && pend_q.size() == 0; k++) tick();
    chk("arst_in_wait", 64'(pend_q.size()), 64'd1);
    do_reset(1'b1, 1'b1);
    lat_min = 1; lat_max = 1;
    repeat (12) tick();
    chk("arst_first_req", 64'(acc_log[0]), 64'h0000);
    chk("arst_first_pop", 64'(pop_log[0].pc), 64'h0000);

    // randomized traffic
    do_reset(1'b0, 1'b0);
    lat_min = 1; lat_max = 3; rand_data = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      start          = ($urandom_range(0, 7) != 0);
      mem_req_ready  = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_addr  = ($urandom_range(0, 3) == 0) ? 16'hFFF8 : 16'($urandom);
      tick();
    end
    redirect_valid = 1'b0;
    start = 1'b0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
